// File: rtl/draw_pixel_read_if.sv
// ---------------------------------------------------------------------------
// draw_pixel_read_if
//
// Purpose: bundles the register strobe bus, the VRAM read port and the
//          result signals of the framebuffer pixel reader into one interface.
//
// Signal summary (directions as seen by the reader, i.e. the slave modport):
//   rd_reg_wr_i    in   register write strobe
//   rd_reg_num_i   in   register index (0=X 1=Y 2=SRC_ADDR 3=SRC_HEIGHT
//                       4=EXECUTE 5=KEY)
//   rd_reg_data_i  in   register write data
//   vram_sel_o     out  VRAM select
//   vram_rd_o      out  VRAM read request
//   vram_addr_o    out  VRAM word address
//   vram_ack_i     in   arbiter grant, vram_data_i valid in the same cycle
//   vram_data_i    in   VRAM read data
//   rd_data_o      out  pixel value
//   rd_valid_o     out  one-cycle result strobe
//   rd_oob_o       out  last result was out of bounds
//   rd_timeout_o   out  last request timed out
//   rd_match_o     out  pixel equals KEY (optional feature)
//   busy_o         out  request in progress
//
// The master modport is the mirror image, used by whoever drives the
// register bus and plays the VRAM arbiter.
// ---------------------------------------------------------------------------
interface draw_pixel_read_if;

    logic        rd_reg_wr_i;
    logic [2:0]  rd_reg_num_i;
    logic [15:0] rd_reg_data_i;

    logic        vram_sel_o;
    logic        vram_rd_o;
    logic [15:0] vram_addr_o;
    logic        vram_ack_i;
    logic [15:0] vram_data_i;

    logic [7:0]  rd_data_o;
    logic        rd_valid_o;
    logic        rd_oob_o;
    logic        rd_timeout_o;
    logic        rd_match_o;
    logic        busy_o;

    modport slave (
        input  rd_reg_wr_i,
        input  rd_reg_num_i,
        input  rd_reg_data_i,
        output vram_sel_o,
        output vram_rd_o,
        output vram_addr_o,
        input  vram_ack_i,
        input  vram_data_i,
        output rd_data_o,
        output rd_valid_o,
        output rd_oob_o,
        output rd_timeout_o,
        output rd_match_o,
        output busy_o
    );

    modport master (
        output rd_reg_wr_i,
        output rd_reg_num_i,
        output rd_reg_data_i,
        input  vram_sel_o,
        input  vram_rd_o,
        input  vram_addr_o,
        output vram_ack_i,
        output vram_data_i,
        input  rd_data_o,
        input  rd_valid_o,
        input  rd_oob_o,
        input  rd_timeout_o,
        input  rd_match_o,
        input  busy_o
    );

endinterface

// File: rtl/draw_pixel_read.sv
// ---------------------------------------------------------------------------
// draw_pixel_read
//
// Purpose: framebuffer pixel reader, the read-side counterpart of the draw
//          unit's pixel writer. Coordinates and the source surface are
//          configured over the register strobe bus; EXECUTE converts (x,y)
//          into a VRAM word address, issues one VRAM read, extracts the 8bpp
//          pixel byte and returns it with a one-cycle valid strobe.
//          Out-of-bounds coordinates and unanswered requests are reported.
//
// Ports:
//   clk       system clock
//   reset_ni  asynchronous, active-low reset
//   bus       draw_pixel_read_if.slave: register bus, VRAM read port and
//             result outputs (see draw_pixel_read_if.sv)
//
// Parameters:
//   VIS_WIDTH   pixels per line (two 8bpp pixels per 16-bit word)
//   LINE_WORDS  VRAM words per line
//   DEF_HEIGHT  reset value of the source height register
//   TIMEOUT     cycles to wait for an ack before giving up (8-bit counter)
//
// Configuration macro:
//   DRAW_PIXEL_READ_KEY_EN  when defined, register 5 holds an 8-bit KEY and
//                           rd_match_o flags successful reads equal to it;
//                           otherwise rd_match_o is tied low and no KEY
//                           storage exists.
// ---------------------------------------------------------------------------
module draw_pixel_read #(
    parameter int VIS_WIDTH  = 320,
    parameter int LINE_WORDS = 160,
    parameter int DEF_HEIGHT = 240,
    parameter int TIMEOUT    = 255
) (
    input  logic             clk,
    input  logic             reset_ni,
    draw_pixel_read_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        REQ   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [2:0] REG_X          = 3'd0;
    localparam logic [2:0] REG_Y          = 3'd1;
    localparam logic [2:0] REG_SRC_ADDR   = 3'd2;
    localparam logic [2:0] REG_SRC_HEIGHT = 3'd3;
    localparam logic [2:0] REG_EXECUTE    = 3'd4;
`ifdef DRAW_PIXEL_READ_KEY_EN
    localparam logic [2:0] REG_KEY        = 3'd5;
`endif

    localparam logic signed [12:0] VIS_W_S   = 13'(VIS_WIDTH);
    localparam logic [15:0]        LINE_W16  = 16'(LINE_WORDS);
    localparam logic [11:0]        DEF_H12   = 12'(DEF_HEIGHT);
    localparam logic [7:0]         TIMEOUT8  = 8'(TIMEOUT);

    state_t state;
    state_t state_next;

    // Configuration registers
    logic [11:0] reg_x;
    logic [11:0] reg_y;
    logic [15:0] reg_src_addr;
    logic [11:0] reg_src_height;

    // Request / result registers
    logic [15:0] addr_q;
    logic        byte_sel;
    logic [7:0]  timeout_cnt;
    logic [7:0]  data_q;
    logic        oob_q;
    logic        timeout_q;

    // Combinational helpers
    logic        execute;
    logic        in_bounds;
    logic [15:0] addr_calc;
    logic [7:0]  pixel;
    logic [7:0]  cnt_inc;
    logic        cnt_hit;
    logic        req_ack;
    logic        req_expire;
    logic        check_oob;
    logic        sel;
    logic        rd;
    logic        busy;
    logic        valid;

    logic signed [12:0] x_ext;
    logic signed [12:0] y_ext;
    logic signed [12:0] h_ext;

    assign execute = bus.rd_reg_wr_i && (bus.rd_reg_num_i == REG_EXECUTE);

    // X, Y and the height are signed 12-bit quantities; widen by one bit so
    // the compare against VIS_WIDTH stays signed without width surprises.
    assign x_ext = {reg_x[11], reg_x};
    assign y_ext = {reg_y[11], reg_y};
    assign h_ext = {reg_src_height[11], reg_src_height};

    assign in_bounds = (x_ext >= 13'sd0) && (y_ext >= 13'sd0) &&
                       (x_ext < VIS_W_S) && (y_ext < h_ext);

    // Only used when in bounds, so y and x are non-negative here. The sum is
    // evaluated in 16 bits on purpose: addresses wrap modulo 2^16.
    assign addr_calc = reg_src_addr
                     + (16'(reg_y) * LINE_W16)
                     + 16'(reg_x[11:1]);

    // Even pixels live in the high byte of the word, odd pixels in the low.
    assign pixel = byte_sel ? bus.vram_data_i[7:0] : bus.vram_data_i[15:8];

    assign cnt_inc    = timeout_cnt + 8'd1;
    assign cnt_hit    = (cnt_inc == TIMEOUT8);
    assign req_ack    = (state == REQ) && bus.vram_ack_i;
    assign req_expire = (state == REQ) && !bus.vram_ack_i && cnt_hit;
    assign check_oob  = (state == CHECK) && !in_bounds;

    // Configuration register writes are accepted in every state; the active
    // request only depends on what was latched in CHECK.
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            reg_x          <= 12'd0;
            reg_y          <= 12'd0;
            reg_src_addr   <= 16'd0;
            reg_src_height <= DEF_H12;
        end else if (bus.rd_reg_wr_i) begin
            case (bus.rd_reg_num_i)
                REG_X:          reg_x          <= bus.rd_reg_data_i[11:0];
                REG_Y:          reg_y          <= bus.rd_reg_data_i[11:0];
                REG_SRC_ADDR:   reg_src_addr   <= bus.rd_reg_data_i;
                REG_SRC_HEIGHT: reg_src_height <= bus.rd_reg_data_i[11:0];
                default:        ;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshake outputs. The VRAM strobes are decoded from
    // the state register so that an async reset drops them immediately.
    always_comb begin
        state_next = state;
        sel        = 1'b0;
        rd         = 1'b0;
        busy       = 1'b0;
        valid      = 1'b0;
        case (state)
            IDLE: begin
                if (execute) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                busy       = 1'b1;
                state_next = in_bounds ? REQ : DONE;
            end
            REQ: begin
                busy = 1'b1;
                sel  = 1'b1;
                rd   = 1'b1;
                // An ack in the expiry cycle still counts as a success.
                if (bus.vram_ack_i || cnt_hit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                valid      = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request latching, timeout counting and result capture. Results are
    // written on the transition into DONE and then hold until the next one.
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            addr_q      <= 16'd0;
            byte_sel    <= 1'b0;
            timeout_cnt <= 8'd0;
            data_q      <= 8'd0;
            oob_q       <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            if ((state == CHECK) && in_bounds) begin
                addr_q      <= addr_calc;
                byte_sel    <= reg_x[0];
                timeout_cnt <= 8'd0;
            end
            if (check_oob) begin
                data_q    <= 8'd0;
                oob_q     <= 1'b1;
                timeout_q <= 1'b0;
            end
            if ((state == REQ) && !bus.vram_ack_i) begin
                timeout_cnt <= cnt_inc;
            end
            if (req_ack) begin
                data_q    <= pixel;
                oob_q     <= 1'b0;
                timeout_q <= 1'b0;
            end
            if (req_expire) begin
                data_q    <= 8'd0;
                oob_q     <= 1'b0;
                timeout_q <= 1'b1;
            end
        end
    end

`ifdef DRAW_PIXEL_READ_KEY_EN
    logic [7:0] reg_key;
    logic       match_q;

    // KEY register and the compare flag, refreshed on every DONE entry.
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            reg_key <= 8'd0;
            match_q <= 1'b0;
        end else begin
            if (bus.rd_reg_wr_i && (bus.rd_reg_num_i == REG_KEY)) begin
                reg_key <= bus.rd_reg_data_i[7:0];
            end
            if (check_oob || req_expire) begin
                match_q <= 1'b0;
            end else if (req_ack) begin
                match_q <= (pixel == reg_key);
            end
        end
    end

    assign bus.rd_match_o = match_q;
`else
    assign bus.rd_match_o = 1'b0;
`endif

    assign bus.vram_sel_o   = sel;
    assign bus.vram_rd_o    = rd;
    assign bus.vram_addr_o  = addr_q;
    assign bus.rd_data_o    = data_q;
    assign bus.rd_valid_o   = valid;
    assign bus.rd_oob_o     = oob_q;
    assign bus.rd_timeout_o = timeout_q;
    assign bus.busy_o       = busy;

endmodule

// File: tb/tb_draw_pixel_read.sv
// ---------------------------------------------------------------------------
// tb_draw_pixel_read
//
// Self-checking bench for draw_pixel_read. A register/coordinate model
// predicts each result (pixel, oob, timeout, match, latency) and pushes it to
// a scoreboard queue when EXECUTE is driven; a monitor pops and compares on
// every rd_valid_o. A VRAM responder plays the arbiter with a configurable
// ack delay and checks every requested address against the model.
// ---------------------------------------------------------------------------
module tb_draw_pixel_read;

    localparam int VIS_WIDTH  = 320;
    localparam int LINE_WORDS = 160;
    localparam int DEF_HEIGHT = 240;
    localparam int TIMEOUT    = 255;

`ifdef DRAW_PIXEL_READ_KEY_EN
    localparam bit KEY_EN = 1'b1;
`else
    localparam bit KEY_EN = 1'b0;
`endif

    typedef struct {
        logic [7:0] data;
        logic       oob;
        logic       timeout;
        logic       match;
        int         lat;
        int         exec_cyc;
    } sb_item_t;

    logic clk;
    logic reset_ni;

    draw_pixel_read_if bus();

    draw_pixel_read #(
        .VIS_WIDTH  (VIS_WIDTH),
        .LINE_WORDS (LINE_WORDS),
        .DEF_HEIGHT (DEF_HEIGHT),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset_ni (reset_ni),
        .bus      (bus)
    );

    int n_compared   = 0;
    int n_mismatched = 0;

    int cyc            = 0;
    int last_drive_cyc = 0;
    int valid_seen     = 0;
    int req_starts     = 0;
    int req_cnt        = 0;
    int last_req_len   = 0;

    // Responder configuration, written by the stimulus process only
    int          ack_delay  = 0;
    bit          ack_never  = 1'b0;
    bit          use_fixed  = 1'b0;
    logic [15:0] fixed_word = 16'h0000;

    logic [15:0] exp_addr_q[$];
    logic [15:0] cur_exp_addr;
    sb_item_t    sb_q[$];
    sb_item_t    mon_item;

    // Reference register model
    int         mdl_x;
    int         mdl_y;
    int         mdl_src;
    int         mdl_h;
    logic [7:0] mdl_key;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0] ^ 8'h5A, a[15:8] + 8'h3C};
    endfunction

    function automatic bit model_in_bounds();
        return (mdl_x >= 0) && (mdl_y >= 0) && (mdl_x < VIS_WIDTH) && (mdl_y < mdl_h);
    endfunction

    function automatic logic [15:0] model_addr();
        int a;
        a = mdl_src + mdl_y * LINE_WORDS + (mdl_x / 2);
        return a[15:0];
    endfunction

    task automatic reset_model();
        mdl_x   = 0;
        mdl_y   = 0;
        mdl_src = 0;
        mdl_h   = DEF_HEIGHT;
        mdl_key = 8'h00;
    endtask

    // One register write cycle; also keeps the reference model in step.
    task automatic applyStimulus(input logic [2:0] num, input logic [15:0] data);
        @(negedge clk);
        bus.rd_reg_wr_i   = 1'b1;
        bus.rd_reg_num_i  = num;
        bus.rd_reg_data_i = data;
        last_drive_cyc    = cyc;
        case (num)
            3'd0: mdl_x   = sext12(data[11:0]);
            3'd1: mdl_y   = sext12(data[11:0]);
            3'd2: mdl_src = int'(data);
            3'd3: mdl_h   = sext12(data[11:0]);
            3'd5: if (KEY_EN) mdl_key = data[7:0];
            default: ;
        endcase
        @(negedge clk);
        bus.rd_reg_wr_i = 1'b0;
    endtask

    task automatic wait_done(input int start_valid);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #1;
            if (valid_seen > start_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) checkOutput("done_wait", 32'd0, 32'd1);
    endtask

    task automatic run_read(input int x, input int y, input int delay, input bit never);
        sb_item_t    it;
        bit          inb;
        logic [15:0] addr;
        logic [15:0] word;
        logic [7:0]  pix;
        int          start_valid;
        int          start_reqs;
        applyStimulus(3'd0, 16'(x));
        applyStimulus(3'd1, 16'(y));
        inb       = model_in_bounds();
        addr      = model_addr();
        ack_delay = delay;
        ack_never = never;
        word      = use_fixed ? fixed_word : mem_word(addr);
        pix       = (mdl_x % 2 != 0) ? word[7:0] : word[15:8];
        it.oob     = !inb;
        it.timeout = inb && never;
        it.data    = (inb && !never) ? pix : 8'h00;
        it.match   = KEY_EN && inb && !never && (pix == mdl_key);
        it.lat     = !inb ? 2 : (never ? TIMEOUT + 2 : 3 + delay);
        if (inb) exp_addr_q.push_back(addr);
        start_valid = valid_seen;
        start_reqs  = req_starts;
        applyStimulus(3'd4, 16'h0000);
        it.exec_cyc = last_drive_cyc;
        sb_q.push_back(it);
        wait_done(start_valid);
        @(negedge clk);
        checkOutput("busy_after_done", 32'(bus.busy_o), 32'd0);
        if (inb) begin
            checkOutput("req_count", 32'(req_starts - start_reqs), 32'd1);
            checkOutput("req_len", 32'(last_req_len), never ? 32'(TIMEOUT) : 32'(delay + 1));
        end else begin
            checkOutput("no_vram_req", 32'(req_starts - start_reqs), 32'd0);
        end
    endtask

    // VRAM arbiter model: acks after ack_delay request cycles and checks
    // the requested address on every request cycle.
    initial begin
        bus.vram_ack_i  = 1'b0;
        bus.vram_data_i = 16'h0000;
        cur_exp_addr    = 16'h0000;
        forever begin
            @(negedge clk);
            if (bus.vram_rd_o && bus.vram_sel_o) begin
                if (req_cnt == 0) begin
                    req_starts++;
                    if (exp_addr_q.size() == 0) begin
                        checkOutput("unexpected_req", 32'd1, 32'd0);
                        cur_exp_addr = 16'h0000;
                    end else begin
                        cur_exp_addr = exp_addr_q.pop_front();
                    end
                end
                checkOutput("vram_addr", 32'(bus.vram_addr_o), 32'(cur_exp_addr));
                if (!ack_never && (req_cnt == ack_delay)) begin
                    bus.vram_ack_i  = 1'b1;
                    bus.vram_data_i = use_fixed ? fixed_word : mem_word(bus.vram_addr_o);
                end else begin
                    bus.vram_ack_i  = 1'b0;
                    bus.vram_data_i = 16'($urandom);
                end
                req_cnt++;
            end else begin
                if (req_cnt != 0) last_req_len = req_cnt;
                req_cnt        = 0;
                bus.vram_ack_i = 1'b0;
            end
        end
    end

    // Result monitor: every valid strobe must match the oldest prediction.
    always @(negedge clk) begin
        if (reset_ni && bus.rd_valid_o) begin
            valid_seen++;
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_valid", 32'd1, 32'd0);
            end else begin
                mon_item = sb_q.pop_front();
                checkOutput("rd_data", 32'(bus.rd_data_o), 32'(mon_item.data));
                checkOutput("rd_oob", 32'(bus.rd_oob_o), 32'(mon_item.oob));
                checkOutput("rd_timeout", 32'(bus.rd_timeout_o), 32'(mon_item.timeout));
                checkOutput("rd_match", 32'(bus.rd_match_o), 32'(mon_item.match));
                checkOutput("latency", 32'(cyc - mon_item.exec_cyc), 32'(mon_item.lat));
                checkOutput("busy_in_done", 32'(bus.busy_o), 32'd1);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_sel"}, 32'(bus.vram_sel_o), 32'd0);
        checkOutput({tag, "_rd"}, 32'(bus.vram_rd_o), 32'd0);
        checkOutput({tag, "_addr"}, 32'(bus.vram_addr_o), 32'd0);
        checkOutput({tag, "_data"}, 32'(bus.rd_data_o), 32'd0);
        checkOutput({tag, "_valid"}, 32'(bus.rd_valid_o), 32'd0);
        checkOutput({tag, "_oob"}, 32'(bus.rd_oob_o), 32'd0);
        checkOutput({tag, "_timeout"}, 32'(bus.rd_timeout_o), 32'd0);
        checkOutput({tag, "_match"}, 32'(bus.rd_match_o), 32'd0);
        checkOutput({tag, "_busy"}, 32'(bus.busy_o), 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        sb_item_t it;
        int       start_valid;
        int       start_reqs;

        reset_model();
        reset_ni          = 1'b0;
        bus.rd_reg_wr_i   = 1'b0;
        bus.rd_reg_num_i  = 3'd0;
        bus.rd_reg_data_i = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset_ni = 1'b1;
        $display("[TB] reset released");

        // Even / odd pixel with the word 0xAB12 at 0x1142
        use_fixed  = 1'b1;
        fixed_word = 16'hAB12;
        applyStimulus(3'd2, 16'h1000);
        applyStimulus(3'd0, 16'd5);
        run_read(4, 2, 0, 1'b0);
        run_read(5, 2, 3, 1'b0);

        // Bounds
        run_read(-1, 2, 0, 1'b0);
        run_read(320, 2, 0, 1'b0);
        run_read(0, 240, 0, 1'b0);
        run_read(0, -1, 0, 1'b0);
        run_read(319, 239, 1, 1'b0);
        run_read(0, 0, 0, 1'b0);

        // Timeout, then a successful read clears the flag
        $display("[TB] timeout sequence");
        run_read(4, 2, 0, 1'b1);
        run_read(4, 2, 0, 1'b0);

        // EXECUTE while busy is ignored
        $display("[TB] execute while busy");
        applyStimulus(3'd0, 16'd4);
        applyStimulus(3'd1, 16'd2);
        ack_delay = 3;
        ack_never = 1'b0;
        exp_addr_q.push_back(16'h1142);
        it.data     = 8'hAB;
        it.oob      = 1'b0;
        it.timeout  = 1'b0;
        it.match    = KEY_EN && (mdl_key == 8'hAB);
        it.lat      = 6;
        start_valid = valid_seen;
        start_reqs  = req_starts;
        applyStimulus(3'd4, 16'h0000);
        it.exec_cyc = last_drive_cyc;
        sb_q.push_back(it);
        applyStimulus(3'd4, 16'h0000);
        applyStimulus(3'd4, 16'h0000);
        wait_done(start_valid);
        repeat (8) @(negedge clk);
        checkOutput("busy_exec_valids", 32'(valid_seen - start_valid), 32'd1);
        checkOutput("busy_exec_reqs", 32'(req_starts - start_reqs), 32'd1);

        // Async reset in the middle of a request
        $display("[TB] reset during request");
        applyStimulus(3'd3, 16'd100);
        applyStimulus(3'd0, 16'd4);
        applyStimulus(3'd1, 16'd2);
        ack_never = 1'b1;
        exp_addr_q.push_back(16'h1142);
        start_valid = valid_seen;
        applyStimulus(3'd4, 16'h0000);
        repeat (4) @(negedge clk);
        checkOutput("pre_reset_rd", 32'(bus.vram_rd_o), 32'd1);
        @(posedge clk);
        #2;
        reset_ni = 1'b0;
        #1;
        check_all_zero("midreq_reset");
        reset_model();
        ack_never = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_ni = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_no_valid", 32'(valid_seen - start_valid), 32'd0);

        // Height back at its default: 239 in bounds, 240 out
        use_fixed = 1'b0;
        run_read(7, 239, 0, 1'b0);
        run_read(7, 240, 0, 1'b0);

        // KEY compare (always tied low when the feature is absent)
        use_fixed  = 1'b1;
        fixed_word = 16'hAB12;
        applyStimulus(3'd2, 16'h1000);
        applyStimulus(3'd5, 16'h0012);
        run_read(5, 2, 1, 1'b0);
        run_read(4, 2, 0, 1'b0);
        run_read(-5, 2, 0, 1'b0);

        // Address wrap past 0xFFFF
        use_fixed = 1'b0;
        applyStimulus(3'd2, 16'hFF00);
        run_read(319, 239, 2, 1'b0);

        // Random coordinates, sources and ack delays
        $display("[TB] random reads");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(3'd2, 16'($urandom));
            run_read(int'($urandom_range(333)) - 3, int'($urandom_range(247)) - 2,
                     int'($urandom_range(4)), 1'b0);
        end

        checkOutput("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        checkOutput("addr_queue_empty", 32'(exp_addr_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/draw_pixel_read.md
Name: draw_pixel_read

Overview:
- Framebuffer pixel reader: the read-side counterpart of the draw unit's pixel writer.
- Accepts coordinate and source configuration over the same XR-style register strobe interface.
- Converts (x,y) to a VRAM word address and issues a single VRAM read request, holding it until the arbiter acknowledges.
- Extracts the 8bpp pixel byte, returns it with a one-cycle valid pulse, and provides out-of-bounds and timeout reporting.

Parameters:
- VIS_WIDTH, 320, pixels per line (8bpp, two pixels per 16-bit word).
- LINE_WORDS, 160, VRAM words per line.
- DEF_HEIGHT, 240, reset value of the source height register.
- TIMEOUT, 255, maximum cycles to wait for vram_ack_i before aborting; 8-bit counter.

Ports:
- clk  in  1  system clock.
- reset_ni  in  1  reset; asynchronous assert, active-low.
- rd_reg_wr_i  in  1  register write strobe.
- rd_reg_num_i  in  3  register index: 0=X, 1=Y, 2=SRC_ADDR, 3=SRC_HEIGHT, 4=EXECUTE, 5=KEY (optional).
- rd_reg_data_i  in  16  register write data.
- vram_sel_o  out  1  VRAM select.
- vram_rd_o  out  1  VRAM read request.
- vram_addr_o  out  16  VRAM word address.
- vram_ack_i  in  1  arbiter grant; vram_data_i is valid in the same cycle.
- vram_data_i  in  16  VRAM read data.
- rd_data_o  out  8  pixel value.
- rd_valid_o  out  1  result strobe, one cycle.
- rd_oob_o  out  1  last result was out of bounds.
- rd_timeout_o  out  1  last request timed out.
- rd_match_o  out  1  pixel equals KEY (optional feature).
- busy_o  out  1  request in progress.

Behaviour:
- Reset (async, reset_ni=0):
  - state=IDLE.
  - All outputs 0; vram_addr_o=0.
  - X=Y=0, SRC_ADDR=0, SRC_HEIGHT=DEF_HEIGHT, timeout counter 0.
- Registers:
  - X and Y take data[11:0], signed 12-bit.
  - SRC_ADDR takes 16 bits; SRC_HEIGHT takes data[11:0].
  - Writes to X, Y, SRC_ADDR and SRC_HEIGHT are accepted in any state. The in-flight request uses values latched at CHECK.
  - EXECUTE (any data) while IDLE starts a read. EXECUTE while busy_o=1 is ignored, not queued.
- FSM states: IDLE -> CHECK -> REQ -> DONE -> IDLE.
- IDLE:
  - On EXECUTE in cycle N, move to CHECK and set busy_o=1 from cycle N+1.
- CHECK (cycle N+1):
  - In bounds when x>=0, y>=0, x<VIS_WIDTH and y<SRC_HEIGHT (signed compare).
  - Out of bounds: go to DONE with rd_data_o=0, rd_oob_o=1, no VRAM access.
  - In bounds: compute addr = SRC_ADDR + y*LINE_WORDS + (x>>1), truncated to 16 bits (wraps modulo 2^16). Latch byte_sel = x[0]. Clear the timeout counter. Go to REQ.
- REQ (from cycle N+2):
  - Hold vram_sel_o=1, vram_rd_o=1 and vram_addr_o stable until a cycle with vram_ack_i=1.
  - In the ack cycle: capture vram_data_i[15:8] when byte_sel=0, or [7:0] when byte_sel=1. Set rd_oob_o=0, rd_timeout_o=0. Deassert sel/rd from the next cycle. Go to DONE.
  - The counter increments in each REQ cycle without ack. When it reaches TIMEOUT: deassert sel/rd, rd_data_o=0, rd_timeout_o=1, go to DONE.
  - An ack in the same cycle the counter hits TIMEOUT counts as success (ack wins).
- DONE:
  - rd_valid_o=1 for exactly one cycle, then IDLE with busy_o=0.
  - rd_data_o, rd_oob_o, rd_timeout_o and rd_match_o hold until the next DONE.
- Latency:
  - Zero-wait ack (ack in the first REQ cycle, N+2): rd_valid_o at N+3.
  - Out of bounds: rd_valid_o at N+2.
- vram_ack_i outside REQ is ignored.
- Reset mid-REQ drops the request immediately (sel/rd low asynchronously). No valid pulse is generated.

Optional Feature:
- Macro DRAW_PIXEL_READ_KEY_EN.
- Defined:
  - Register 5 holds an 8-bit KEY (data[7:0], reset 0).
  - rd_match_o is updated in the DONE-entry cycle: 1 when the read succeeded and the pixel equals KEY; 0 on out-of-bounds or timeout.
- Undefined:
  - rd_match_o is tied to 0.
  - Writes to register 5 are ignored; no KEY storage is synthesized.

Test Plan:
- Even pixel: SRC_ADDR=0x1000, X=5 replaced by X=4, Y=2, EXECUTE; ack in the first REQ cycle with data 0xAB12 -> vram_addr_o=0x1142, rd_data_o=0xAB, rd_valid_o at N+3.
- Odd pixel with 3-cycle ack delay: X=5, Y=2 -> addr 0x1142 held stable 3 cycles, rd_data_o=0x12, one valid pulse.
- Bounds: X=-1, then X=320, then Y=SRC_HEIGHT=240, each EXECUTE -> no vram_rd_o, rd_oob_o=1, rd_data_o=0, valid at N+2.
- Timeout with ack never asserted -> sel/rd drop after 255 REQ cycles, rd_timeout_o=1. A following EXECUTE with ack succeeds and clears rd_timeout_o.
- EXECUTE while busy plus an async reset during REQ -> second EXECUTE ignored (single valid). Reset forces all outputs 0 and SRC_HEIGHT=240.
- With DRAW_PIXEL_READ_KEY_EN: KEY=0x12, odd-pixel read of 0xAB12 -> rd_match_o=1; even pixel -> 0.
